// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: sync, data-enable, zero-based coordinates
// and line/frame strobes, stepping on a pixel clock-enable.
module vga_timing_gen #(
  parameter int H_SYNC = 128,
  parameter int H_BP   = 88,
  parameter int H_ACT  = 800,
  parameter int H_FP   = 40,
  parameter int V_SYNC = 4,
  parameter int V_BP   = 23,
  parameter int V_ACT  = 600,
  parameter int V_FP   = 1,
  parameter int H_POL  = 0,
  parameter int V_POL  = 0,
  parameter int CW     = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  input  logic          restart,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;

  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_SYNC_E = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SYNC_E = CW'(V_SYNC);
  localparam logic [CW-1:0] H_ACT_B  = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] V_ACT_B  = CW'(V_SYNC + V_BP);
  localparam logic [CW-1:0] H_ACT_E  = CW'(H_SYNC + H_BP + H_ACT);
  localparam logic [CW-1:0] V_ACT_E  = CW'(V_SYNC + V_BP + V_ACT);
  localparam logic          H_LVL    = (H_POL != 0);
  localparam logic          V_LVL    = (V_POL != 0);

  logic [CW-1:0] h_reg, h_next;
  logic [CW-1:0] v_reg, v_next;
  logic          update;

  logic          hs_next, vs_next, de_next, ls_next, fs_next;
  logic          h_act_next, v_act_next;
  logic [CW-1:0] x_next, y_next;

  assign update = restart | pix_en;

  // restart wins over pix_en and parks the counters at the pre-start point
  always_comb begin
    h_next = h_reg;
    v_next = v_reg;
    if (restart) begin
      h_next = H_LAST;
      v_next = V_LAST;
    end else if (pix_en) begin
      if (h_reg == H_LAST) begin
        h_next = '0;
        v_next = (v_reg == V_LAST) ? '0 : v_reg + ONE;
      end else begin
        h_next = h_reg + ONE;
      end
    end
  end

  // Outputs are decoded from the next position so they register alongside it.
  always_comb begin
    h_act_next = (h_next >= H_ACT_B) && (h_next < H_ACT_E);
    v_act_next = (v_next >= V_ACT_B) && (v_next < V_ACT_E);
    de_next    = h_act_next & v_act_next;
    hs_next    = (h_next < H_SYNC_E) ? H_LVL : ~H_LVL;
    vs_next    = (v_next < V_SYNC_E) ? V_LVL : ~V_LVL;
    x_next     = de_next ? (h_next - H_ACT_B) : '0;
    y_next     = de_next ? (v_next - V_ACT_B) : '0;
    ls_next    = (h_next == '0);
    fs_next    = ls_next && (v_next == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_reg       <= H_LAST;
      v_reg       <= V_LAST;
      hsync       <= ~H_LVL;
      vsync       <= ~V_LVL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (update) begin
      h_reg       <= h_next;
      v_reg       <= v_next;
      hsync       <= hs_next;
      vsync       <= vs_next;
      de          <= de_next;
      x           <= x_next;
      y           <= y_next;
      line_start  <= ls_next;
      frame_start <= fs_next;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 800x600 mode and a tiny
// positive-polarity mode, checked against hand-computed vectors.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default-mode DUT
  logic        rst_a, pix_en_a, restart_a;
  logic        hs_a, vs_a, de_a, ls_a, fs_a;
  logic [10:0] x_a, y_a;

  // 10/2/2/4 x 1/1/3/1 mode, positive syncs
  logic        rst_b, pix_en_b, restart_b;
  logic        hs_b, vs_b, de_b, ls_b, fs_b;
  logic [4:0]  x_b, y_b;

  vga_timing_gen dut_a (
    .clk(clk), .rst(rst_a), .pix_en(pix_en_a), .restart(restart_a),
    .hsync(hs_a), .vsync(vs_a), .de(de_a), .x(x_a), .y(y_a),
    .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .H_SYNC(10), .H_BP(2), .H_ACT(2), .H_FP(4),
    .V_SYNC(1), .V_BP(1), .V_ACT(3), .V_FP(1),
    .H_POL(1), .V_POL(1), .CW(5)
  ) dut_b (
    .clk(clk), .rst(rst_b), .pix_en(pix_en_b), .restart(restart_b),
    .hsync(hs_b), .vsync(vs_b), .de(de_b), .x(x_b), .y(y_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  typedef struct {
    int   n;
    logic hs, vs, de, ls, fs;
    int   x, y;
  } vec_t;

  vec_t tbl_a[12];
  vec_t tbl_b[14];

  int total  = 0;
  int passed = 0;

  function automatic logic [31:0] pk(input logic hs, input logic vs, input logic de,
                                     input logic ls, input logic fs,
                                     input logic [10:0] xx, input logic [10:0] yy);
    return {5'b0, hs, vs, de, ls, fs, xx, yy};
  endfunction

  function automatic logic [31:0] pk_vec(input vec_t t);
    return pk(t.hs, t.vs, t.de, t.ls, t.fs, 11'(t.x), 11'(t.y));
  endfunction

  function automatic logic [31:0] out_a();
    return pk(hs_a, vs_a, de_a, ls_a, fs_a, x_a, y_a);
  endfunction

  function automatic logic [31:0] out_b();
    return pk(hs_b, vs_b, de_b, ls_b, fs_b, 11'(x_b), 11'(y_b));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
      $display("check %s ok: %h", name, act);
    end else begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    int de_cnt, fs_cnt, ls_cnt;

    //               n      hs vs de ls fs x    y
    tbl_a[0]  = '{0,     0, 0, 0, 1, 1, 0,   0};
    tbl_a[1]  = '{127,   0, 0, 0, 0, 0, 0,   0};
    tbl_a[2]  = '{128,   1, 0, 0, 0, 0, 0,   0};
    tbl_a[3]  = '{1055,  1, 0, 0, 0, 0, 0,   0};
    tbl_a[4]  = '{1056,  0, 0, 0, 1, 0, 0,   0};
    tbl_a[5]  = '{4223,  1, 0, 0, 0, 0, 0,   0};
    tbl_a[6]  = '{4224,  0, 1, 0, 1, 0, 0,   0};
    tbl_a[7]  = '{28727, 1, 1, 0, 0, 0, 0,   0};
    tbl_a[8]  = '{28728, 1, 1, 1, 0, 0, 0,   0};
    tbl_a[9]  = '{29527, 1, 1, 1, 0, 0, 799, 0};
    tbl_a[10] = '{29528, 1, 1, 0, 0, 0, 0,   0};
    tbl_a[11] = '{29568, 0, 1, 0, 1, 0, 0,   0};

    tbl_b[0]  = '{0,   1, 1, 0, 1, 1, 0, 0};
    tbl_b[1]  = '{9,   1, 1, 0, 0, 0, 0, 0};
    tbl_b[2]  = '{10,  0, 1, 0, 0, 0, 0, 0};
    tbl_b[3]  = '{18,  1, 0, 0, 1, 0, 0, 0};
    tbl_b[4]  = '{48,  0, 0, 1, 0, 0, 0, 0};
    tbl_b[5]  = '{49,  0, 0, 1, 0, 0, 1, 0};
    tbl_b[6]  = '{50,  0, 0, 0, 0, 0, 0, 0};
    tbl_b[7]  = '{67,  0, 0, 1, 0, 0, 1, 1};
    tbl_b[8]  = '{84,  0, 0, 1, 0, 0, 0, 2};
    tbl_b[9]  = '{85,  0, 0, 1, 0, 0, 1, 2};
    tbl_b[10] = '{102, 0, 0, 0, 0, 0, 0, 0};
    tbl_b[11] = '{107, 0, 0, 0, 0, 0, 0, 0};
    tbl_b[12] = '{108, 1, 1, 0, 1, 1, 0, 0};
    tbl_b[13] = '{126, 1, 0, 0, 1, 0, 0, 0};

    rst_a = 1'b1; pix_en_a = 1'b0; restart_a = 1'b0;
    rst_b = 1'b1; pix_en_b = 1'b0; restart_b = 1'b0;
    repeat (3) tick();
    check("a_reset", out_a(), pk(1, 1, 0, 0, 0, 0, 0));
    check("b_reset", out_b(), pk(0, 0, 0, 0, 0, 0, 0));

    // ---- default mode, pix_en tied high ----
    rst_a = 1'b0; pix_en_a = 1'b1;
    idx = 0; de_cnt = 0;
    for (int step = 1; step <= 29569; step++) begin
      tick();
      if (de_a) de_cnt++;
      if (idx < 12 && tbl_a[idx].n == step - 1) begin
        check($sformatf("a_n%0d", tbl_a[idx].n), out_a(), pk_vec(tbl_a[idx]));
        idx++;
      end
    end
    check("a_de_count_to_v28", 32'(de_cnt), 32'd800);

    // restart mid-active line at x=100 (h=316, v=28)
    repeat (316) tick();
    check("a_x100", out_a(), pk(1, 1, 1, 0, 0, 100, 1));
    restart_a = 1'b1;
    tick();
    restart_a = 1'b0;
    check("a_restart_prestart", out_a(), pk(1, 1, 0, 0, 0, 0, 0));
    tick();
    check("a_restart_frame_start", out_a(), pk(0, 0, 0, 1, 1, 0, 0));

    // async reset pulse while vsync is active
    repeat (10) tick();
    check("a_in_vsync", out_a(), pk(0, 0, 0, 0, 0, 0, 0));
    #2;
    rst_a = 1'b1;
    #1;
    check("a_async_reset", out_a(), pk(1, 1, 0, 0, 0, 0, 0));
    tick();
    rst_a = 1'b0;
    tick();
    check("a_reset_recover", out_a(), pk(0, 0, 0, 1, 1, 0, 0));
    pix_en_a = 1'b0;

    // ---- small mode, pix_en tied high: H_TOTAL=18, V_TOTAL=6 ----
    rst_b = 1'b0; pix_en_b = 1'b1;
    idx = 0; de_cnt = 0; fs_cnt = 0; ls_cnt = 0;
    for (int step = 1; step <= 127; step++) begin
      tick();
      if (step <= 108) begin
        if (de_b) de_cnt++;
        if (ls_b) ls_cnt++;
      end
      if (fs_b) fs_cnt++;
      if (idx < 14 && tbl_b[idx].n == step - 1) begin
        check($sformatf("b_n%0d", tbl_b[idx].n), out_b(), pk_vec(tbl_b[idx]));
        idx++;
      end
    end
    check("b_de_per_frame", 32'(de_cnt), 32'd6);
    check("b_ls_per_frame", 32'(ls_cnt), 32'd6);
    check("b_fs_in_127", 32'(fs_cnt), 32'd2);

    // ---- small mode, pix_en every other cycle ----
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    de_cnt = 0; fs_cnt = 0; ls_cnt = 0;
    for (int c = 1; c <= 432; c++) begin
      pix_en_b = c[0];
      tick();
      if (de_b) de_cnt++;
      if (ls_b) ls_cnt++;
      if (fs_b) fs_cnt++;
      if (c == 1) check("b_half_first", out_b(), pk(1, 1, 0, 1, 1, 0, 0));
      if (c == 2) check("b_half_hold", out_b(), pk(1, 1, 0, 1, 1, 0, 0));
      if (c == 3) check("b_half_step2", out_b(), pk(1, 1, 0, 0, 0, 0, 0));
    end
    check("b_half_fs_cycles", 32'(fs_cnt), 32'd4);
    check("b_half_ls_cycles", 32'(ls_cnt), 32'd24);
    check("b_half_de_cycles", 32'(de_cnt), 32'd24);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
